column_frame_strobe_ctrl: RTL and testbench

//   Per-column frame-strobe generator feeding the FrameStrobe input of the bottom tile of one fabric column.

---
 rtl/column_frame_strobe_ctrl.sv | 132 +++++++++++++
 tb/tb_column_frame_strobe_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/column_frame_strobe_ctrl.sv
// Per-column frame-strobe generator: filters config-bus frame writes by column and
// emits a timed one-hot FrameStrobe pulse. Optional feature macro: STROBE_COUNT_EN.
module column_frame_strobe_ctrl #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned ColSelectWidth  = 5,
  parameter int unsigned FrameIdxWidth   = 5,
  parameter int unsigned Col             = 0,
  parameter int unsigned SetupCycles     = 1,
  parameter int unsigned PulseCycles     = 2,
  parameter int unsigned HoldCycles      = 1
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic [ColSelectWidth-1:0]  ColAddr,
  input  logic [FrameIdxWidth-1:0]   FrameIdx,
  input  logic                       Req_valid,
  output logic                       Req_ready,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Busy,
  output logic                       Done,
  output logic                       AddrErr
`ifdef STROBE_COUNT_EN
  ,
  output logic [15:0]                StrobeCount
`endif
);

  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] SetupLoad = CntW'(SetupCycles - 1);
  localparam logic [CntW-1:0] PulseLoad = CntW'(PulseCycles - 1);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(HoldCycles - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t                   state;
  logic [CntW-1:0]          cnt;
  logic [FrameIdxWidth-1:0] idx;

  logic own_col;
  logic idx_bad;
  logic accept;

  assign own_col = (ColAddr == ColSelectWidth'(Col));
  assign idx_bad = (32'(FrameIdx) >= MaxFramesPerCol);
  assign accept  = Req_valid & Req_ready;

  function automatic logic [MaxFramesPerCol-1:0] decode(input logic [FrameIdxWidth-1:0] i);
    decode = MaxFramesPerCol'(1) << i;
  endfunction

  // Single counter is reloaded on every state entry and counts down to zero.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      FrameStrobe <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      AddrErr     <= 1'b0;
      Req_ready   <= 1'b0;
    end else begin
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      case (state)
        IDLE: begin
          Req_ready <= 1'b1;
          // Foreign-column requests are consumed silently; the shared bus owner is elsewhere.
          if (accept && own_col) begin
            if (idx_bad) begin
              AddrErr <= 1'b1;
            end else begin
              idx       <= FrameIdx;
              Req_ready <= 1'b0;
              Busy      <= 1'b1;
              if (SetupCycles == 0) begin
                state       <= STROBE;
                cnt         <= PulseLoad;
                FrameStrobe <= decode(FrameIdx);
              end else begin
                state <= SETUP;
                cnt   <= SetupLoad;
              end
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state       <= STROBE;
            cnt         <= PulseLoad;
            FrameStrobe <= decode(idx);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state       <= HOLD;
            cnt         <= HoldLoad;
            FrameStrobe <= '0;
            Done        <= (HoldCycles == 1);
          end else begin
            cnt <= cnt - CntW'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            Busy      <= 1'b0;
            Req_ready <= 1'b1;
          end else begin
            cnt  <= cnt - CntW'(1);
            Done <= (cnt == CntW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STROBE_COUNT_EN
  // Counts completed strobes only; rejects and address errors never raise Done.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      StrobeCount <= '0;
    end else if (Done && (StrobeCount != 16'hFFFF)) begin
      StrobeCount <= StrobeCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_column_frame_strobe_ctrl.sv
// Scoreboard bench for column_frame_strobe_ctrl: instance a uses default timing,
// instance b uses SetupCycles=0; both answer to column 3.
module tb_column_frame_strobe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  col_addr;
  logic [4:0]  frame_idx;
  logic        va, vb;
  logic        rdy_a, rdy_b;
  logic [19:0] fs_a, fs_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
`ifdef STROBE_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif

  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int          cyc;
    logic [19:0] fs;
    logic        done;
    logic        err;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  column_frame_strobe_ctrl #(.Col(3)) dut_a (
    .UserCLK(clk), .Reset(rst), .ColAddr(col_addr), .FrameIdx(frame_idx),
    .Req_valid(va), .Req_ready(rdy_a), .FrameStrobe(fs_a), .Busy(busy_a),
    .Done(done_a), .AddrErr(err_a)
`ifdef STROBE_COUNT_EN
    , .StrobeCount(cnt_a)
`endif
  );

  column_frame_strobe_ctrl #(.Col(3), .SetupCycles(0)) dut_b (
    .UserCLK(clk), .Reset(rst), .ColAddr(col_addr), .FrameIdx(frame_idx),
    .Req_valid(vb), .Req_ready(rdy_b), .FrameStrobe(fs_b), .Busy(busy_b),
    .Done(done_b), .AddrErr(err_b)
`ifdef STROBE_COUNT_EN
    , .StrobeCount(cnt_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input bit b, input int c, input logic [19:0] fs, input logic d, input logic e);
    ev_t ev;
    ev.cyc = c; ev.fs = fs; ev.done = d; ev.err = e;
    if (b) qb.push_back(ev);
    else   qa.push_back(ev);
  endtask

  // Good request accepted at edge k: strobe for two cycles after setup, then Done.
  task automatic push_good(input bit b, input int k, input logic [19:0] fs);
    int s;
    s = b ? 0 : 1;
    push(b, k + s,     fs,    1'b0, 1'b0);
    push(b, k + s + 1, fs,    1'b0, 1'b0);
    push(b, k + s + 2, 20'h0, 1'b1, 1'b0);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge k.
  task automatic req(input bit b, input logic [4:0] c, input logic [4:0] i, output int k);
    bit ok;
    col_addr = c; frame_idx = i;
    if (b) vb = 1'b1; else va = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ((b ? rdy_b : rdy_a) === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      nvec++; nerr++;
      $display("FAIL req_timeout: Req_ready never seen for col %0d idx %0d", c, i);
    end
    k = cyc + 1;
    @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever an instance shows a strobe, Done or AddrErr.
  always @(negedge clk) begin
    ev_t e;
    #1;
    if (fs_a != 20'h0 || done_a || err_a) begin
      if (qa.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL a_unexpected: strobe %0h done %0b err %0b at cycle %0d, none expected", fs_a, done_a, err_a, cyc);
      end else begin
        e = qa.pop_front();
        chk("a_cycle", cyc, e.cyc);
        chk("a_strobe", fs_a, e.fs);
        chk("a_done", done_a, e.done);
        chk("a_addrerr", err_a, e.err);
      end
    end
    if (fs_b != 20'h0 || done_b || err_b) begin
      if (qb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL b_unexpected: strobe %0h done %0b err %0b at cycle %0d, none expected", fs_b, done_b, err_b, cyc);
      end else begin
        e = qb.pop_front();
        chk("b_cycle", cyc, e.cyc);
        chk("b_strobe", fs_b, e.fs);
        chk("b_done", done_b, e.done);
        chk("b_addrerr", err_b, e.err);
      end
    end
  end

  initial begin
    int k, k2;
    rst = 1'b1; va = 1'b0; vb = 1'b0; col_addr = '0; frame_idx = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", rdy_a, 1'b0);
    chk("reset_busy", busy_a, 1'b0);
    chk("reset_strobe", fs_a, 20'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", rdy_a, 1'b1);

    // Own column, idx 7; inputs changed while busy must be ignored.
    req(1'b0, 5'd3, 5'd7, k);
    va = 1'b0; col_addr = 5'd5; frame_idx = 5'd1;
    push_good(1'b0, k, 20'h00080);
    chk("t1_busy", busy_a, 1'b1);
    chk("t1_ready_busy", rdy_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("t1_ready_at_done", rdy_a, 1'b0);
    @(negedge clk);
    chk("t1_ready_back", rdy_a, 1'b1);
    chk("t1_busy_clear", busy_a, 1'b0);

    // Foreign column: consumed with no visible effect.
    req(1'b0, 5'd5, 5'd2, k);
    va = 1'b0;
    chk("t2_ready", rdy_a, 1'b1);
    chk("t2_busy", busy_a, 1'b0);
    repeat (3) @(negedge clk);

    // Own column, out-of-range frame index.
    req(1'b0, 5'd3, 5'd20, k);
    va = 1'b0;
    push(1'b0, k, 20'h0, 1'b0, 1'b1);
    chk("t3_busy", busy_a, 1'b0);
    chk("t3_ready", rdy_a, 1'b1);
    repeat (2) @(negedge clk);

    // Back-to-back with Req_valid held high: idx 0 then idx 19.
    req(1'b0, 5'd3, 5'd0, k);
    frame_idx = 5'd19;
    push_good(1'b0, k, 20'h00001);
    req(1'b0, 5'd3, 5'd19, k2);
    va = 1'b0;
    chk("t4_b2b_latency", k2, k + 5);
    push_good(1'b0, k2, 20'h80000);
    repeat (5) @(negedge clk);

    // Reset during STROBE: strobe drops, no Done.
    req(1'b0, 5'd3, 5'd4, k);
    va = 1'b0;
    push(1'b0, k + 1, 20'h00010, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_strobe_reset", fs_a, 20'h0);
    chk("t5_ready_in_reset", rdy_a, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", rdy_a, 1'b1);
    chk("t5_busy_after", busy_a, 1'b0);
    repeat (4) @(negedge clk);

    // Zero setup instance: three good requests and one error.
    req(1'b1, 5'd3, 5'd2, k);
    vb = 1'b0;
    push_good(1'b1, k, 20'h00004);
    req(1'b1, 5'd3, 5'd9, k);
    vb = 1'b0;
    push_good(1'b1, k, 20'h00200);
    req(1'b1, 5'd3, 5'd25, k);
    vb = 1'b0;
    push(1'b1, k, 20'h0, 1'b0, 1'b1);
    req(1'b1, 5'd3, 5'd13, k);
    vb = 1'b0;
    push_good(1'b1, k, 20'h02000);
    repeat (5) @(negedge clk);
`ifdef STROBE_COUNT_EN
    chk("t6_strobe_count", cnt_b, 16'd3);
`endif
    chk("b_ready_end", rdy_b, 1'b1);

    repeat (2) @(negedge clk);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
